poly_loader: RTL and testbench
==============================

# poly_loader

Upstream feeder for `tt_um_emern_pixel_core`. Receives polygon and background definitions over a slave SPI link and stages them in a shadow register file. On a commit command it copies the shadow set into the active set at the next frame boundary. The active set drives the pixel core's packed vertex, color and enable buses, so the rasterizer never sees a half-updated scene.

## Interface
Parameters:
- `N_POLY`, 4: number of polygon slots; must match `N_POLY` in constants.v.
- `WPX`, 10: vertex x width.
- `WPY`, 9: vertex y width.
- `WCOLOR`, 6: color width, rrggbb.
- Derived payload width `PW = 3*(WPX+WPY)+WCOLOR+1`. This is 64 at the defaults and must be a multiple of 8.

Ports:
- `clk`  in  1  system/pixel clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `spi_sck`  in  1  SPI clock, mode 0, asynchronous to `clk`. Maximum frequency is `clk`/4.
- `spi_cs_n`  in  1  SPI chip select, active-low, asynchronous.
- `spi_mosi`  in  1  SPI data, MSB first, asynchronous.
- `frame_start`  in  1  one-cycle pulse from the VGA timing generator during vertical blanking.
- `cmp_en`  out  N_POLY  active per-polygon enable.
- `v0_x`, `v1_x`, `v2_x`  out  WPX*N_POLY each  active packed x vertices. Slot k occupies bits [k*WPX +: WPX].
- `v0_y`, `v1_y`, `v2_y`  out  WPY*N_POLY each  active packed y vertices.
- `poly_color`  out  WCOLOR*N_POLY  active packed polygon colors.
- `background_color`  out  WCOLOR  active background.
- `commit_pending`  out  1  high while a commit waits for `frame_start`.

## Operation
Input synchronization:
- `spi_sck`, `spi_cs_n` and `spi_mosi` each pass through a 2-flop synchronizer.
- A rising edge of synchronized sck while synchronized cs_n is low shifts synchronized mosi into the receive shifter.

Transaction framing:
- A transaction is the interval during which cs_n is low.
- A bit counter resets whenever cs_n is high.
- The first 8 bits form the command byte `cmd`.
- FSM states: IDLE, CMD, PAYLOAD, DRAIN.
- IDLE goes to CMD when cs_n falls.
- After bit 8, CMD decodes `cmd[7:6]`:
  - 00 polygon write, slot = `cmd[1:0]`: go to PAYLOAD and expect PW bits. If slot >= N_POLY, go to DRAIN instead.
  - 01 background write: go to PAYLOAD and expect 8 bits; bits [WCOLOR-1:0] are used.
  - 10 commit: set the commit request, then go to DRAIN.
  - 11 reserved: go to DRAIN.
- When the last payload bit arrives, PAYLOAD writes the shadow register in the next cycle, then goes to DRAIN.
- Polygon payload, MSB first: {v0_x, v0_y, v1_x, v1_y, v2_x, v2_y, color, en}. At the defaults: bits 63:54 v0_x, 53:45 v0_y, 44:35 v1_x, 34:26 v1_y, 25:16 v2_x, 15:7 v2_y, 6:1 color, 0 en.
- DRAIN ignores all further bits.
- Any state returns to IDLE when cs_n rises.
- If cs_n rises before the payload is complete, the transaction is aborted: the partial payload is discarded and the shadow is unchanged.

Commit:
- A commit sets `commit_pending`.
- On a `frame_start` cycle with `commit_pending` already high, all shadow registers (every slot plus background) are copied to the active registers in one cycle, and `commit_pending` clears.
- A commit decoded in the same cycle as `frame_start` is not applied on that `frame_start`. It stays pending for the next one.
- Repeated commits while pending have no additional effect.
- Shadow writes after a commit but before `frame_start` are included in the copy.
- `frame_start` with nothing pending: no change.

Reset:
- All active outputs, all shadow registers and `commit_pending` are 0.
- The FSM returns to IDLE and the bit counter clears.
- Reset mid-transaction aborts it. The remaining bits of that transaction are ignored until cs_n has been seen high.

## Timing
- Synchronized edge detection occurs 3 clk cycles after the pin edge. The setup of mosi relative to sck must cover this.
- A shadow write is visible internally 1 cycle after the last bit is captured.
- A commit sets `commit_pending` 1 cycle after command bit 8 is captured.
- Active outputs and the clearing of `commit_pending` update on the clock edge that samples `frame_start`, and are visible the following cycle.
- All outputs are registered, with no combinational path from inputs.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles. Required: every output is 0 and `commit_pending`=0.
- Polygon write plus commit:
  - Send cmd 0x01 with a 64-bit payload giving v0=(100,50), v1=(300,50), v2=(200,400), color 0x30, en=1. Send commit 0x80, then pulse `frame_start`.
  - Required: `commit_pending`=1 before the pulse. Slot 1 is unchanged before the pulse.
  - Required after the pulse: `v0_x[19:10]`=100, `v2_y[17:9]`=400, `poly_color[11:6]`=0x30, `cmp_en`=4'b0010.
- Abort: start a polygon write to slot 2, raise cs_n after 40 bits, commit, then `frame_start`. Required: slot 2 remains 0.
- Background and commit coincidence:
  - Send cmd 0x40 with data 0x0C, then commit, timed so the commit decode coincides with `frame_start`.
  - Required: `background_color` is still 0 after that pulse, and becomes 0x0C after the next pulse.
- Ignored commands: send cmd 0xC0 and cmd 0x00 with extra trailing bytes beyond 64 payload bits. Required: the reserved command changes nothing. Slot 0 holds the first 64 payload bits; the trailing bytes are ignored.
- Reset mid-transaction: assert `rst_n`=0 during a payload, release it, and keep clocking the rest of the payload. Required: no shadow change. The next clean transaction decodes correctly.

Source files
------------

// File: rtl/poly_loader.sv
// poly_loader: SPI slave that stages polygon/background data in a shadow
// register file and copies it to the active set on frame_start.
module poly_loader #(
   parameter int N_POLY = 4,
   parameter int WPX    = 10,
   parameter int WPY    = 9,
   parameter int WCOLOR = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     spi_sck,
   input  logic                     spi_cs_n,
   input  logic                     spi_mosi,
   input  logic                     frame_start,
   output logic [N_POLY-1:0]        cmp_en,
   output logic [WPX*N_POLY-1:0]    v0_x,
   output logic [WPX*N_POLY-1:0]    v1_x,
   output logic [WPX*N_POLY-1:0]    v2_x,
   output logic [WPY*N_POLY-1:0]    v0_y,
   output logic [WPY*N_POLY-1:0]    v1_y,
   output logic [WPY*N_POLY-1:0]    v2_y,
   output logic [WCOLOR*N_POLY-1:0] poly_color,
   output logic [WCOLOR-1:0]        background_color,
   output logic                     commit_pending
);

   localparam int PW    = 3*(WPX+WPY)+WCOLOR+1;
   localparam int CW    = $clog2(PW+1);
   localparam int O_COL = 1;
   localparam int O_V2Y = O_COL + WCOLOR;
   localparam int O_V2X = O_V2Y + WPY;
   localparam int O_V1Y = O_V2X + WPX;
   localparam int O_V1X = O_V1Y + WPY;
   localparam int O_V0Y = O_V1X + WPX;
   localparam int O_V0X = O_V0Y + WPY;

   typedef enum logic [1:0] {
      S_IDLE, S_CMD, S_PAYLOAD, S_DRAIN
   } state_t;

   logic [1:0]    r_sck_s;
   logic [1:0]    r_cs_s;
   logic [1:0]    r_mosi_s;
   logic          r_sck_d;
   logic          r_cs_d;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_need;
   logic [PW-1:0] r_shift;
   logic [1:0]    r_slot;
   logic          r_is_bg;
   logic          r_pending;

   logic [WPX*N_POLY-1:0]    r_sh_v0x, r_sh_v1x, r_sh_v2x;
   logic [WPY*N_POLY-1:0]    r_sh_v0y, r_sh_v1y, r_sh_v2y;
   logic [WCOLOR*N_POLY-1:0] r_sh_col;
   logic [N_POLY-1:0]        r_sh_en;
   logic [WCOLOR-1:0]        r_sh_bg;

   logic [WPX*N_POLY-1:0]    r_act_v0x, r_act_v1x, r_act_v2x;
   logic [WPY*N_POLY-1:0]    r_act_v0y, r_act_v1y, r_act_v2y;
   logic [WCOLOR*N_POLY-1:0] r_act_col;
   logic [N_POLY-1:0]        r_act_en;
   logic [WCOLOR-1:0]        r_act_bg;

   logic w_sck_rise;
   logic w_cs_fall;
   logic w_apply;
   logic w_mosi;

   // cs sync resets to "low" so a transaction cut by reset is not re-entered
   // until cs_n has actually been seen high and then falls again.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sck_s  <= '0;
         r_cs_s   <= '0;
         r_mosi_s <= '0;
         r_sck_d  <= 1'b0;
         r_cs_d   <= 1'b0;
      end else begin
         r_sck_s  <= {r_sck_s[0], spi_sck};
         r_cs_s   <= {r_cs_s[0], spi_cs_n};
         r_mosi_s <= {r_mosi_s[0], spi_mosi};
         r_sck_d  <= r_sck_s[1];
         r_cs_d   <= r_cs_s[1];
      end
   end

   assign w_sck_rise = r_sck_s[1] & ~r_sck_d;
   assign w_cs_fall  = r_cs_d & ~r_cs_s[1];
   assign w_apply    = frame_start & r_pending;
   assign w_mosi     = r_mosi_s[1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_need    <= '0;
         r_shift   <= '0;
         r_slot    <= '0;
         r_is_bg   <= 1'b0;
         r_pending <= 1'b0;
         r_sh_v0x  <= '0;
         r_sh_v1x  <= '0;
         r_sh_v2x  <= '0;
         r_sh_v0y  <= '0;
         r_sh_v1y  <= '0;
         r_sh_v2y  <= '0;
         r_sh_col  <= '0;
         r_sh_en   <= '0;
         r_sh_bg   <= '0;
      end else begin
         if (w_apply)
            r_pending <= 1'b0;
         if (r_cs_s[1]) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (w_cs_fall) begin
                     r_state <= S_CMD;
                     r_cnt   <= '0;
                  end
               end
               S_CMD: begin
                  if (r_cnt == CW'(8)) begin
                     r_cnt <= '0;
                     unique case (r_shift[7:6])
                        2'b00: begin
                           if (int'(r_shift[1:0]) < N_POLY) begin
                              r_slot  <= r_shift[1:0];
                              r_is_bg <= 1'b0;
                              r_need  <= CW'(PW);
                              r_state <= S_PAYLOAD;
                           end else begin
                              r_state <= S_DRAIN;
                           end
                        end
                        2'b01: begin
                           r_is_bg <= 1'b1;
                           r_need  <= CW'(8);
                           r_state <= S_PAYLOAD;
                        end
                        2'b10: begin
                           r_pending <= 1'b1;
                           r_state   <= S_DRAIN;
                        end
                        default: r_state <= S_DRAIN;
                     endcase
                  end else if (w_sck_rise) begin
                     r_shift <= {r_shift[PW-2:0], w_mosi};
                     r_cnt   <= r_cnt + CW'(1);
                  end
               end
               S_PAYLOAD: begin
                  if (r_cnt == r_need) begin
                     if (r_is_bg) begin
                        r_sh_bg <= r_shift[WCOLOR-1:0];
                     end else begin
                        r_sh_v0x[r_slot*WPX +: WPX]       <= r_shift[O_V0X +: WPX];
                        r_sh_v0y[r_slot*WPY +: WPY]       <= r_shift[O_V0Y +: WPY];
                        r_sh_v1x[r_slot*WPX +: WPX]       <= r_shift[O_V1X +: WPX];
                        r_sh_v1y[r_slot*WPY +: WPY]       <= r_shift[O_V1Y +: WPY];
                        r_sh_v2x[r_slot*WPX +: WPX]       <= r_shift[O_V2X +: WPX];
                        r_sh_v2y[r_slot*WPY +: WPY]       <= r_shift[O_V2Y +: WPY];
                        r_sh_col[r_slot*WCOLOR +: WCOLOR] <= r_shift[O_COL +: WCOLOR];
                        r_sh_en[r_slot]                   <= r_shift[0];
                     end
                     r_state <= S_DRAIN;
                  end else if (w_sck_rise) begin
                     r_shift <= {r_shift[PW-2:0], w_mosi};
                     r_cnt   <= r_cnt + CW'(1);
                  end
               end
               S_DRAIN: ;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_act_v0x <= '0;
         r_act_v1x <= '0;
         r_act_v2x <= '0;
         r_act_v0y <= '0;
         r_act_v1y <= '0;
         r_act_v2y <= '0;
         r_act_col <= '0;
         r_act_en  <= '0;
         r_act_bg  <= '0;
      end else if (w_apply) begin
         r_act_v0x <= r_sh_v0x;
         r_act_v1x <= r_sh_v1x;
         r_act_v2x <= r_sh_v2x;
         r_act_v0y <= r_sh_v0y;
         r_act_v1y <= r_sh_v1y;
         r_act_v2y <= r_sh_v2y;
         r_act_col <= r_sh_col;
         r_act_en  <= r_sh_en;
         r_act_bg  <= r_sh_bg;
      end
   end

   assign cmp_en           = r_act_en;
   assign v0_x             = r_act_v0x;
   assign v1_x             = r_act_v1x;
   assign v2_x             = r_act_v2x;
   assign v0_y             = r_act_v0y;
   assign v1_y             = r_act_v1y;
   assign v2_y             = r_act_v2y;
   assign poly_color       = r_act_col;
   assign background_color = r_act_bg;
   assign commit_pending   = r_pending;

endmodule

// File: tb/tb_poly_loader.sv
// tb_poly_loader: directed SPI transactions against a scene-level model
// of shadow/active polygon sets, checked on every clk cycle.
module tb_poly_loader;

   localparam int H = 4;

   logic clk = 1'b0;
   logic rst_n, spi_sck, spi_cs_n, spi_mosi, frame_start;
   logic [3:0]  cmp_en;
   logic [39:0] v0_x, v1_x, v2_x;
   logic [35:0] v0_y, v1_y, v2_y;
   logic [23:0] poly_color;
   logic [5:0]  background_color;
   logic        commit_pending;

   poly_loader dut (
      .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi), .frame_start(frame_start), .cmp_en(cmp_en),
      .v0_x(v0_x), .v1_x(v1_x), .v2_x(v2_x),
      .v0_y(v0_y), .v1_y(v1_y), .v2_y(v2_y),
      .poly_color(poly_color), .background_color(background_color),
      .commit_pending(commit_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] v0x, v1x, v2x;
      logic [8:0] v0y, v1y, v2y;
      logic [5:0] col;
      logic       en;
   } poly_t;

   poly_t      sh[4], act[4];
   logic [5:0] sh_bg, act_bg;
   logic       m_pend;
   bit         chk_en = 0;
   bit         pend_known = 0;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors < 40)
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] mk_poly(
      input int ax, ay, bx, by, cx, cy, input logic [5:0] c, input logic e);
      logic [9:0] x0, x1, x2;
      logic [8:0] y0, y1, y2;
      x0 = 10'(ax); y0 = 9'(ay); x1 = 10'(bx);
      y1 = 9'(by); x2 = 10'(cx); y2 = 9'(cy);
      return {x0, y0, x1, y1, x2, y2, c, e};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         sh[k] = '{default: '0};
         act[k] = '{default: '0};
      end
      sh_bg = '0; act_bg = '0; m_pend = 0;
   endtask

   task automatic model_frame();
      if (m_pend) begin
         act = sh;
         act_bg = sh_bg;
         m_pend = 0;
      end
   endtask

   // Effect of one complete cs-low transaction of n bits, MSB first.
   task automatic model_xfer(input logic [127:0] d, input int n);
      logic [7:0]  cmd, b;
      logic [63:0] p;
      if (n < 8) return;
      cmd = d[n-1 -: 8];
      case (cmd[7:6])
         2'b00: if (n - 8 >= 64) begin
            p = d[n-9 -: 64];
            sh[cmd[1:0]].v0x = p[63:54];
            sh[cmd[1:0]].v0y = p[53:45];
            sh[cmd[1:0]].v1x = p[44:35];
            sh[cmd[1:0]].v1y = p[34:26];
            sh[cmd[1:0]].v2x = p[25:16];
            sh[cmd[1:0]].v2y = p[15:7];
            sh[cmd[1:0]].col = p[6:1];
            sh[cmd[1:0]].en  = p[0];
         end
         2'b01: if (n - 8 >= 8) begin
            b = d[n-9 -: 8];
            sh_bg = b[5:0];
         end
         2'b10: m_pend = 1;
         default: ;
      endcase
   endtask

   always @(negedge clk) begin
      logic [39:0] e0x, e1x, e2x;
      logic [35:0] e0y, e1y, e2y;
      logic [23:0] ec;
      logic [3:0]  ee;
      if (chk_en) begin
         for (int k = 0; k < 4; k++) begin
            e0x[k*10 +: 10] = act[k].v0x;
            e1x[k*10 +: 10] = act[k].v1x;
            e2x[k*10 +: 10] = act[k].v2x;
            e0y[k*9 +: 9]   = act[k].v0y;
            e1y[k*9 +: 9]   = act[k].v1y;
            e2y[k*9 +: 9]   = act[k].v2y;
            ec[k*6 +: 6]    = act[k].col;
            ee[k]           = act[k].en;
         end
         chk("v0_x", 64'(v0_x), 64'(e0x));
         chk("v1_x", 64'(v1_x), 64'(e1x));
         chk("v2_x", 64'(v2_x), 64'(e2x));
         chk("v0_y", 64'(v0_y), 64'(e0y));
         chk("v1_y", 64'(v1_y), 64'(e1y));
         chk("v2_y", 64'(v2_y), 64'(e2y));
         chk("poly_color", 64'(poly_color), 64'(ec));
         chk("cmp_en", 64'(cmp_en), 64'(ee));
         chk("background", 64'(background_color), 64'(act_bg));
         if (pend_known)
            chk("pending", 64'(commit_pending), 64'(m_pend));
      end
   end

   task automatic spi_begin();
      @(negedge clk) spi_cs_n = 1'b0;
      repeat (H) @(negedge clk);
   endtask

   task automatic spi_bit(input logic b);
      spi_mosi = b;
      repeat (H) @(negedge clk);
      spi_sck = 1'b1;
      repeat (H) @(negedge clk);
      spi_sck = 1'b0;
   endtask

   task automatic spi_end();
      repeat (H) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (4*H) @(negedge clk);
   endtask

   task automatic spi_xfer(input logic [127:0] d, input int n);
      pend_known = 0;
      spi_begin();
      for (int i = n - 1; i >= 0; i--) spi_bit(d[i]);
      spi_end();
      model_xfer(d, n);
      pend_known = 1;
   endtask

   task automatic pulse_frame();
      @(negedge clk) frame_start = 1'b1;
      @(posedge clk) model_frame();
      @(negedge clk) frame_start = 1'b0;
      @(negedge clk);
   endtask

   // Commit whose decode edge is the same edge that samples frame_start.
   task automatic commit_coincide();
      logic [7:0] c;
      c = 8'h80;
      pend_known = 0;
      spi_begin();
      for (int i = 7; i >= 1; i--) spi_bit(c[i]);
      spi_mosi = c[0];
      repeat (H) @(negedge clk);
      spi_sck = 1'b1;
      repeat (3) @(negedge clk);
      frame_start = 1'b1;
      @(posedge clk);
      model_frame();
      m_pend = 1;
      @(negedge clk) frame_start = 1'b0;
      spi_sck = 1'b0;
      spi_end();
      pend_known = 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] p1, p2, p0, p3;
      logic [71:0] t;
      rst_n = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1;
      spi_mosi = 1'b0; frame_start = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      chk("rst cmp_en", 64'(cmp_en), 64'd0);
      chk("rst v0_x", 64'(v0_x), 64'd0);
      chk("rst bg", 64'(background_color), 64'd0);
      chk("rst pending", 64'(commit_pending), 64'd0);
      chk_en = 1; pend_known = 1;
      repeat (4) @(negedge clk);

      p1 = mk_poly(100, 50, 300, 50, 200, 400, 6'h30, 1'b1);
      spi_xfer({8'h01, p1}, 72);
      spi_xfer(128'h80, 8);
      chk("commit pending", 64'(commit_pending), 64'd1);
      chk("slot1 before", 64'(v0_x[19:10]), 64'd0);
      pulse_frame();
      chk("slot1 v0_x", 64'(v0_x[19:10]), 64'd100);
      chk("slot1 v2_y", 64'(v2_y[17:9]), 64'd400);
      chk("slot1 color", 64'(poly_color[11:6]), 64'h30);
      chk("slot1 en", 64'(cmp_en), 64'b0010);
      pulse_frame();

      p2 = mk_poly(7, 8, 9, 10, 11, 12, 6'h15, 1'b1);
      t = {8'h02, p2};
      spi_xfer(128'(t[71:32]), 40);
      spi_xfer(128'h80, 8);
      pulse_frame();
      chk("abort slot2", 64'(v0_x[29:20]), 64'd0);
      chk("abort en", 64'(cmp_en), 64'b0010);

      spi_xfer({8'h40, 8'h0C}, 16);
      commit_coincide();
      repeat (2) @(negedge clk);
      chk("bg coincide", 64'(background_color), 64'd0);
      chk("pend coincide", 64'(commit_pending), 64'd1);
      pulse_frame();
      chk("bg next", 64'(background_color), 64'h0C);
      chk("pend clr", 64'(commit_pending), 64'd0);

      p0 = mk_poly(1, 2, 1023, 511, 5, 6, 6'h2A, 1'b1);
      spi_xfer({8'hC0, 16'hFFFF}, 24);
      spi_xfer({8'h00, p0, 16'hABCD}, 88);
      spi_xfer(128'h80, 8);
      spi_xfer(128'h80, 8);
      pulse_frame();
      chk("slot0 v1_x", 64'(v1_x[9:0]), 64'd1023);
      chk("slot0 v1_y", 64'(v1_y[8:0]), 64'd511);
      chk("slot0 color", 64'(poly_color[5:0]), 64'h2A);
      chk("en 0+1", 64'(cmp_en), 64'b0011);
      chk("bg kept", 64'(background_color), 64'h0C);

      p3 = mk_poly(640, 480, 10, 20, 639, 479, 6'h3F, 1'b1);
      t = {8'h03, p3};
      spi_begin();
      for (int i = 71; i >= 52; i--) spi_bit(t[i]);
      @(negedge clk) rst_n = 1'b0;
      chk_en = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1;
      for (int i = 51; i >= 0; i--) spi_bit(t[i]);
      spi_end();
      chk("mid rst en", 64'(cmp_en), 64'd0);
      chk("mid rst pend", 64'(commit_pending), 64'd0);
      spi_xfer(128'h80, 8);
      pulse_frame();
      chk("mid rst shadow", 64'(cmp_en), 64'd0);
      spi_xfer({8'h03, p3}, 72);
      spi_xfer(128'h80, 8);
      pulse_frame();
      chk("clean en", 64'(cmp_en), 64'b1000);
      chk("clean v2_x", 64'(v2_x[39:30]), 64'd639);
      chk("clean color", 64'(poly_color[23:18]), 64'h3F);

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
